// File: rtl/div_seq.sv
// ---------------------------------------------------------------------------
// div_seq
//
// Sequential signed divider. Takes a WIDTH-bit two's-complement dividend and
// divisor and runs a radix-2 restoring division on their magnitudes, one
// quotient bit per cycle. It then applies sign correction so that the
// quotient truncates toward zero and the remainder follows the sign of the
// dividend. A start/busy/done handshake frames each operation. Latency from
// the accepting edge to done is WIDTH+1 cycles, whatever the data.
//
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   start     - request a division; only sampled while idle
//   a         - dividend, signed, sampled with start
//   b         - divisor, signed, sampled with start
//   busy      - high while a division is in progress
//   done      - one-cycle pulse when quotient/remainder/div_zero update
//   quotient  - signed quotient, truncated toward zero
//   remainder - signed remainder, sign follows the dividend
//   div_zero  - set with done when b was zero, held until the next start
// ---------------------------------------------------------------------------
module div_seq #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIXUP
  } state_t;

  state_t             state_q,     state_d;
  logic [WIDTH-1:0]   dvd_q,       dvd_d;
  logic [WIDTH:0]     dsr_q,       dsr_d;
  logic [WIDTH-1:0]   rem_q,       rem_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic               neg_quo_q,   neg_quo_d;
  logic               neg_rem_q,   neg_rem_d;
  logic               zero_q,      zero_d;
  logic               busy_q,      busy_d;
  logic               done_q,      done_d;
  logic [WIDTH-1:0]   quotient_q,  quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               div_zero_q,  div_zero_d;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH-1:0]   rem_sh;
  logic [WIDTH:0]     trial;
  logic               fits;

  // Operand magnitudes and the restoring step.
  // |-2^(WIDTH-1)| = 2^(WIDTH-1) still fits WIDTH bits when read as unsigned,
  // so negating in WIDTH bits is exact for every input.
  // The partial remainder always stays below |b| <= 2^(WIDTH-1), so after the
  // shift it still fits WIDTH bits. The trial subtraction is one bit wider, and
  // its top bit is the borrow: no borrow means the divisor fits.
  always_comb begin
    abs_a  = a[WIDTH-1] ? -a : a;
    abs_b  = b[WIDTH-1] ? -b : b;
    rem_sh = (rem_q << 1) | WIDTH'(dvd_q[WIDTH-1]);
    trial  = {1'b0, rem_sh} - dsr_q;
    fits   = ~trial[WIDTH];
  end

  // Next-state logic for the whole divider.
  // The dividend register doubles as the quotient register: each step shifts
  // one dividend bit out of the top and one quotient bit in at the bottom.
  // A zero divisor runs through the same sequence. Every trial "fits", so the
  // magnitude quotient is all ones and the remainder collects |a|, which sign
  // correction turns back into a. Only the quotient needs forcing to -1.
  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dsr_d       = dsr_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    zero_d      = zero_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d      = abs_a;
          dsr_d      = {1'b0, abs_b};
          rem_d      = '0;
          cnt_d      = '0;
          neg_quo_d  = a[WIDTH-1] ^ b[WIDTH-1];
          neg_rem_d  = a[WIDTH-1];
          zero_d     = (b == '0);
          div_zero_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = CALC;
        end
      end

      CALC: begin
        rem_d = fits ? trial[WIDTH-1:0] : rem_sh;
        dvd_d = (dvd_q << 1) | WIDTH'(fits);
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIXUP;
        end
      end

      FIXUP: begin
        quotient_d  = zero_q ? '1 : (neg_quo_q ? -dvd_q : dvd_q);
        remainder_d = neg_rem_q ? -rem_q : rem_q;
        div_zero_d  = zero_q;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. Reset aborts any division in flight and
  // clears every register, so an aborted operation never produces done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dvd_q       <= '0;
      dsr_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      zero_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dsr_q       <= dsr_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      zero_q      <= zero_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_div_seq.sv
// ---------------------------------------------------------------------------
// tb_div_seq
//
// Scoreboard bench for div_seq (WIDTH=6). Stimulus tasks push the expected
// result and the accepting cycle into a queue. A negedge monitor pops an
// entry on every done pulse and compares quotient, remainder, div_zero,
// busy and latency. Expected results come from integer / and %.
// ---------------------------------------------------------------------------
module tb_div_seq;

  localparam int W   = 6;
  localparam int LAT = W + 1;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   doneCount = 0;

  div_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  // Free-running clock and a cycle counter that advances on every rising edge.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // One comparison: count it, and report it if the values differ.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Reference: signed integer division truncating toward zero, masked to W
  // bits. A zero divisor gives -1 with the dividend as the remainder.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    int   ia;
    int   ib;
    ia    = int'($signed(av));
    ib    = int'($signed(bv));
    e.acc = 0;
    if (ib == 0) begin
      e.q  = '1;
      e.r  = av;
      e.dz = 1'b1;
    end else begin
      e.q  = W'(ia / ib);
      e.r  = W'(ia % ib);
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Called at a negedge: drive operands with start high and log the expected
  // result against the rising edge that accepts them. Start is left high.
  task automatic issueAtEdge(input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    e     = model(av, bv);
    e.acc = cyc;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    issueAtEdge(av, bv);
    start = 1'b0;
  endtask

  // Wait for the scoreboard to empty, bounded.
  task automatic waitDrain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", sb.size(), 0);
    sb.delete();
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done === 1'b1) begin
      doneCount++;
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("quotient", quotient, e.q);
        checkOutput("remainder", remainder, e.r);
        checkOutput("div_zero", div_zero, e.dz);
        checkOutput("busy_at_done", busy, 0);
        checkOutput("latency", cyc - e.acc, LAT);
      end
    end
  end

  // Global watchdog so the run always ends.
  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: got timeout required finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  int dirA[8] = '{7, -7, 7, -32, -32, 5, 4, 20};
  int dirB[8] = '{2,  2, -2, -1,   1, 0, 2,  3};

  initial begin
    int           n;
    int           doneBefore;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    // Reset values.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_quotient", quotient, 0);
    checkOutput("rst_remainder", remainder, 0);
    checkOutput("rst_div_zero", div_zero, 0);
    rst_n = 1'b1;

    // Directed cases, including overflow, divide by zero and its clearing.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(W'(dirA[i]), W'(dirB[i]));
      waitDrain();
    end

    // Exhaustive sweep over all nonzero divisors.
    for (int ai = 0; ai < 64; ai++) begin
      for (int bi = 1; bi < 64; bi++) begin
        applyStimulus(W'(ai), W'(bi));
        waitDrain();
      end
    end

    // Random operands, with zero divisors mixed in.
    for (int i = 0; i < 200; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      applyStimulus(ra, rb);
      waitDrain();
    end

    // Back-to-back: start held high, new operands issued in each done cycle.
    @(negedge clk);
    issueAtEdge(W'(-19), W'(5));
    for (int k = 0; k < 2; k++) begin
      n = 0;
      @(negedge clk);
      while (done !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      checkOutput("b2b_done_seen", done, 1);
      if (k == 0) issueAtEdge(W'(31), W'(-4));
      else        issueAtEdge(W'(-32), W'(7));
    end
    start = 1'b0;
    waitDrain();

    // Start pulsed while busy must be ignored.
    applyStimulus(W'(20), W'(3));
    @(negedge clk);
    a     = W'(1);
    b     = W'(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDrain();
    repeat (LAT + 2) @(negedge clk);

    // Reset in the middle of a division: outputs clear, no done for it.
    @(negedge clk);
    a     = W'(25);
    b     = W'(4);
    start = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    doneBefore = doneCount;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_quotient", quotient, 0);
    checkOutput("abort_remainder", remainder, 0);
    checkOutput("abort_div_zero", div_zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 3) @(negedge clk);
    checkOutput("no_done_after_abort", doneCount, doneBefore);
    applyStimulus(W'(25), W'(4));
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
